// File: rtl/fft_pkg.sv
// Shared types for the FFT sequencer and butterfly datapath: sample format and sequencer FSM states.
package fft_pkg;

    localparam int HALF_W   = 25;
    localparam int SAMPLE_W = 2 * HALF_W;

    typedef struct packed {
        logic [HALF_W-1:0] re;
        logic [HALF_W-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_seq_state_e;

    function automatic sample_t sample_unpack(input logic [SAMPLE_W-1:0] raw);
        sample_t smp;
        smp.re = raw[SAMPLE_W-1:HALF_W];
        smp.im = raw[HALF_W-1:0];
        return smp;
    endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// Resettable fixed-depth shift register used to align sequencer outputs with memory and butterfly latency.
module fft_seq_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Tap 0 takes the input, every later tap takes its predecessor.
    always_comb begin
        pipe_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Shift register; reset clears every tap so no stale valid survives.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT address/control sequencer: one butterfly pair per cycle, draining between stages.
// Define FFT_SEQ_INV_EN to add inv_i / tw_conj_o for inverse transforms.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int RD_LAT   = 1,
    parameter int BFLY_LAT = 2,
    localparam int ADDR_W  = $clog2(N_POINTS),
    localparam int STAGE_W = ($clog2(ADDR_W) > 1) ? $clog2(ADDR_W) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
`ifdef FFT_SEQ_INV_EN
    input  logic              inv_i,
    output logic              tw_conj_o,
`endif
    output logic              ready_o,
    output logic              done_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_a_o,
    output logic [ADDR_W-1:0] rd_addr_b_o,
    output logic [ADDR_W-2:0] tw_idx_o,
    output logic              bfly_valid_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_a_o,
    output logic [ADDR_W-1:0] wr_addr_b_o
);

    localparam int D      = RD_LAT + BFLY_LAT;
    localparam int HALF   = N_POINTS / 2;
    localparam int K_W    = ADDR_W - 1;
    localparam int DCNT_W = $clog2(D + 1);

    fft_seq_state_e     state_q, state_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0]  rd_addr_b_q, rd_addr_b_d;
    logic [K_W-1:0]     tw_q, tw_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               accept_s;
`ifdef FFT_SEQ_INV_EN
    logic               inv_q, inv_d;
    logic               conj_q, conj_d;
`endif

    // Lower address of the pair: group * 2 * span + pos, with span = 1 << s.
    function automatic logic [ADDR_W-1:0] pair_base(input logic [K_W-1:0] k, input int s);
        logic [ADDR_W-1:0] kx;
        logic [ADDR_W-1:0] span;
        kx   = {1'b0, k};
        span = ADDR_W'(1) << s;
        return ((kx >> s) << (s + 1)) | (kx & (span - ADDR_W'(1)));
    endfunction

    function automatic logic [K_W-1:0] tw_index(input logic [K_W-1:0] k, input int s);
        logic [ADDR_W-1:0] kx;
        logic [ADDR_W-1:0] pos;
        kx  = {1'b0, k};
        pos = kx & ((ADDR_W'(1) << s) - ADDR_W'(1));
        return K_W'(pos << (ADDR_W - 1 - s));
    endfunction

    assign accept_s = start_i && ready_q && (state_q == ST_IDLE);

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            s_q         <= {STAGE_W{1'b0}};
            k_q         <= {K_W{1'b0}};
            dcnt_q      <= {DCNT_W{1'b0}};
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= {ADDR_W{1'b0}};
            rd_addr_b_q <= {ADDR_W{1'b0}};
            tw_q        <= {K_W{1'b0}};
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
`ifdef FFT_SEQ_INV_EN
            inv_q       <= 1'b0;
            conj_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_q        <= tw_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
`ifdef FFT_SEQ_INV_EN
            inv_q       <= inv_d;
            conj_q      <= conj_d;
`endif
        end
    end

    // Next-state and counter logic; DRAIN lasts D cycles so the last write lands before the next stage reads.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
`ifdef FFT_SEQ_INV_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ISSUE;
                    s_d     = {STAGE_W{1'b0}};
                    k_d     = {K_W{1'b0}};
`ifdef FFT_SEQ_INV_EN
                    inv_d   = inv_i;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_q == K_W'(HALF - 1)) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = {DCNT_W{1'b0}};
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DCNT_W'(D - 1)) begin
                    if (s_q == STAGE_W'(ADDR_W - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        s_d     = s_q + STAGE_W'(1);
                        k_d     = {K_W{1'b0}};
                    end
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                s_d     = {STAGE_W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode, registered one cycle behind the state.
    always_comb begin
        rd_en_d     = 1'b0;
        rd_addr_a_d = {ADDR_W{1'b0}};
        rd_addr_b_d = {ADDR_W{1'b0}};
        tw_d        = {K_W{1'b0}};
        ready_d     = (state_q == ST_IDLE);
        done_d      = (state_q == ST_DONE);
`ifdef FFT_SEQ_INV_EN
        conj_d      = 1'b0;
`endif
        if (state_q == ST_ISSUE) begin
            rd_en_d     = 1'b1;
            rd_addr_a_d = pair_base(k_q, int'(s_q));
            rd_addr_b_d = pair_base(k_q, int'(s_q)) | (ADDR_W'(1) << int'(s_q));
            tw_d        = tw_index(k_q, int'(s_q));
`ifdef FFT_SEQ_INV_EN
            conj_d      = inv_q;
`endif
        end else begin
            rd_en_d = 1'b0;
        end
    end

    logic [K_W:0]          val_dout_s;
    logic [2*ADDR_W:0]     wr_dout_s;

    fft_seq_delay #(.WIDTH(K_W + 1), .DEPTH(RD_LAT)) u_val_dly (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  ({rd_en_q, tw_q}),
        .dout_o (val_dout_s)
    );

    fft_seq_delay #(.WIDTH(2 * ADDR_W + 1), .DEPTH(D)) u_wr_dly (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
        .dout_o (wr_dout_s)
    );

`ifdef FFT_SEQ_INV_EN
    fft_seq_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_conj_dly (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (conj_q),
        .dout_o (tw_conj_o)
    );
`endif

    assign ready_o      = ready_q;
    assign done_o       = done_q;
    assign stage_o      = s_q;
    assign rd_en_o      = rd_en_q;
    assign rd_addr_a_o  = rd_addr_a_q;
    assign rd_addr_b_o  = rd_addr_b_q;
    assign bfly_valid_o = val_dout_s[K_W];
    assign tw_idx_o     = val_dout_s[K_W-1:0];
    assign wr_en_o      = wr_dout_s[2*ADDR_W];
    assign wr_addr_a_o  = wr_dout_s[2*ADDR_W-1:ADDR_W];
    assign wr_addr_b_o  = wr_dout_s[ADDR_W-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed, table-driven bench for fft_stage_sequencer at default parameters (N=16, RD_LAT=1, BFLY_LAT=2).
module tb_fft_stage_sequencer;

    localparam int NC = 64;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       ready_o, done_o, rd_en_o, bfly_valid_o, wr_en_o;
    logic [1:0] stage_o;
    logic [3:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [2:0] tw_idx_o;
`ifdef FFT_SEQ_INV_EN
    logic       inv_i;
    logic       tw_conj_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
`ifdef FFT_SEQ_INV_EN
        .inv_i        (inv_i),
        .tw_conj_o    (tw_conj_o),
`endif
        .ready_o      (ready_o),
        .done_o       (done_o),
        .stage_o      (stage_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_a_o  (rd_addr_a_o),
        .rd_addr_b_o  (rd_addr_b_o),
        .tw_idx_o     (tw_idx_o),
        .bfly_valid_o (bfly_valid_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_a_o  (wr_addr_a_o),
        .wr_addr_b_o  (wr_addr_b_o)
    );

    typedef struct {
        int cyc;
        int st;
        int a;
        int b;
        int tw;
    } vec_t;

    vec_t vecs[8];

    logic       log_rd[NC], log_bv[NC], log_wr[NC], log_done[NC], log_rdy[NC];
    logic [3:0] log_a[NC], log_b[NC], log_wa[NC], log_wb[NC];
    logic [2:0] log_tw[NC];
    logic [1:0] log_st[NC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int errs;
        int rd_cnt;
        int done_cnt;
        int rd_cyc[$];
        int wr_cyc[$];
        logic exp_rd;

        // (cycle of rd_en, stage, a, b, twiddle); k = cycle - 11*stage - 1
        vecs[0] = '{1, 0, 0, 1, 0};
        vecs[1] = '{2, 0, 2, 3, 0};
        vecs[2] = '{3, 0, 4, 5, 0};
        vecs[3] = '{17, 1, 9, 11, 4};
        vecs[4] = '{23, 2, 0, 4, 0};
        vecs[5] = '{24, 2, 1, 5, 2};
        vecs[6] = '{27, 2, 8, 12, 0};
        vecs[7] = '{37, 3, 3, 11, 3};

        rst_i   = 1'b0;
        start_i = 1'b0;
`ifdef FFT_SEQ_INV_EN
        inv_i   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle_ready_%0d", i), {31'd0, ready_o}, 32'd1);
            chk($sformatf("idle_quiet_%0d", i),
                {rd_en_o, bfly_valid_o, wr_en_o, done_o, stage_o, rd_addr_a_o, rd_addr_b_o,
                 tw_idx_o, wr_addr_a_o, wr_addr_b_o}, 32'd0);
        end

        // Edge 0 accepts the start; cycle c is the interval after edge c.
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            log_rd[c]   = rd_en_o;
            log_a[c]    = rd_addr_a_o;
            log_b[c]    = rd_addr_b_o;
            log_tw[c]   = tw_idx_o;
            log_bv[c]   = bfly_valid_o;
            log_wr[c]   = wr_en_o;
            log_wa[c]   = wr_addr_a_o;
            log_wb[c]   = wr_addr_b_o;
            log_st[c]   = stage_o;
            log_done[c] = done_o;
            log_rdy[c]  = ready_o;
            start_i     = (c == 20);
        end

        foreach (vecs[i]) begin
            int c;
            c = vecs[i].cyc;
            chk($sformatf("rd_en_c%0d", c), {31'd0, log_rd[c]}, 32'd1);
            chk($sformatf("rd_ab_c%0d", c), {24'd0, log_a[c], log_b[c]},
                (vecs[i].a << 4) | vecs[i].b);
            chk($sformatf("stage_c%0d", c), {30'd0, log_st[c]}, vecs[i].st);
            chk($sformatf("bv_tw_c%0d", c + 1), {28'd0, log_bv[c+1], log_tw[c+1]},
                32'd8 | vecs[i].tw);
            chk($sformatf("wr_c%0d", c + 3), {23'd0, log_wr[c+3], log_wa[c+3], log_wb[c+3]},
                32'd256 | (vecs[i].a << 4) | vecs[i].b);
        end

        errs     = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c < NC; c++) begin
            exp_rd = (c >= 1) && (c <= 44) && (((c - 1) % 11) < 8);
            if (log_rd[c] !== exp_rd) errs++;
            if (log_rd[c] === 1'b1) begin
                rd_cnt++;
                rd_cyc.push_back(c);
            end
            if (log_wr[c] === 1'b1) wr_cyc.push_back(c);
            if (log_done[c] === 1'b1) done_cnt++;
        end
        chk("rd_pattern_errs", errs, 32'd0);
        chk("rd_total", rd_cnt, 32'd32);
        chk("done_single", done_cnt, 32'd1);
        chk("done_c45", {31'd0, log_done[45]}, 32'd1);
        chk("ready_c45_c46", {30'd0, log_rdy[45], log_rdy[46]}, 32'd1);
        chk("stage_c10_c11", {28'd0, log_st[10], log_st[11]}, 32'd1);

        errs = 0;
        for (int c = 0; c < NC; c++) begin
            if (c < 3) begin
                if (log_wr[c] !== 1'b0) errs++;
            end else begin
                if (log_wr[c] !== log_rd[c-3]) errs++;
                if (log_wr[c] === 1'b1 && (log_wa[c] !== log_a[c-3] || log_wb[c] !== log_b[c-3])) errs++;
            end
            if (c >= 1 && log_bv[c] !== log_rd[c-1]) errs++;
        end
        chk("wr_bv_alignment_errs", errs, 32'd0);

        if (rd_cyc.size() == 32 && wr_cyc.size() == 32) begin
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("no_raw_stage%0d", s),
                    {31'd0, wr_cyc[8*s+7] < rd_cyc[8*s+8]}, 32'd1);
            end
        end else begin
            chk("event_counts", {rd_cyc.size(), wr_cyc.size()} == {32'd32, 32'd32}, 32'd1);
        end

        // Second transform, reset during stage 1 ISSUE.
        start_i = 1'b1;
`ifdef FFT_SEQ_INV_EN
        inv_i   = 1'b1;
`endif
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 0; c < 14; c++) @(negedge clk);
        chk("mid_rd_stage1", {29'd0, rd_en_o, stage_o}, 32'd5);
`ifdef FFT_SEQ_INV_EN
        chk("mid_tw_conj", {31'd0, tw_conj_o}, 32'd1);
`endif
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        chk("post_rst_outputs", {28'd0, rd_en_o, wr_en_o, bfly_valid_o, ready_o}, 32'd1);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wr_en_o !== 1'b0 || rd_en_o !== 1'b0) errs++;
        end
        chk("post_rst_no_wr", errs, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Sequences an in-place radix-2 DIT FFT over a dual-port sample memory feeding the `butterfly` datapath. It issues one butterfly pair per cycle: read addresses, butterfly-valid timing, twiddle index, and delayed write-back addresses. Between stages it drains the datapath pipeline so no stage reads data before the previous stage has written it. It sits between the transform-start control and the memory/butterfly pair.

## Interface
- `N_POINTS`, 16: transform size; power of two, ≥4.
- `RD_LAT`, 1: memory read latency in cycles; ≥1.
- `BFLY_LAT`, 2: butterfly input-to-output latency in cycles; ≥1.
- Derived: `ADDR_W = $clog2(N_POINTS)`, `L = ADDR_W` stages, `D = RD_LAT + BFLY_LAT`.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  start request; accepted only when `ready_o`=1.
- `ready_o`  out  1  idle, can accept start.
- `done_o`  out  1  one-cycle pulse when the transform completes.
- `stage_o`  out  max(1,$clog2(ADDR_W))  current stage index.
- `rd_en_o`  out  1  read pair this cycle.
- `rd_addr_a_o` / `rd_addr_b_o`  out  ADDR_W  pair read addresses.
- `tw_idx_o`  out  ADDR_W-1  twiddle ROM index, aligned with `bfly_valid_o`.
- `bfly_valid_o`  out  1  memory data is valid at butterfly inputs (`rd_en_o` delayed `RD_LAT`).
- `wr_en_o`  out  1  butterfly outputs valid; write the pair back.
- `wr_addr_a_o` / `wr_addr_b_o`  out  ADDR_W  write-back addresses (read addresses delayed `D`).

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE: `start_i`=1 at a clock edge. Stage counter s=0, pair counter k=0.
- ISSUE: `rd_en_o`=1 every cycle; k increments 0..N/2-1.
  - span = 1<<s, group = k>>s, pos = k&(span-1).
  - a = group·2·span + pos; b = a + span.
  - twiddle = pos << (L-1-s), delayed `RD_LAT` to align with `bfly_valid_o`.
  - At k=N/2-1 go to DRAIN.
- DRAIN: lasts exactly D cycles, with `rd_en_o`=0.
  - If s<L-1: s++, k=0, go to ISSUE.
  - Else go to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `start_i` outside IDLE is ignored. Input is assumed bit-reversed; output is in natural order.
- All address arithmetic is unsigned, ADDR_W bits, with no overflow by construction.

## Timing
- Reset (`rst_i`=0 at an edge): state IDLE, `ready_o`=1, all other outputs 0, and all delay-line valid bits cleared. Reset mid-transform discards pending writes, so no `wr_en_o` follows reset.
- Take start accepted at edge 0. The first `rd_en_o` is in cycle 1.
- `bfly_valid_o` follows each `rd_en_o` by `RD_LAT` cycles. `wr_en_o` and its addresses follow by D cycles.
- The last write of stage s occurs in the same cycle as the last DRAIN cycle. The first read of stage s+1 is the next cycle, so there is no read-after-write overlap.
- `done_o` rises L·(N/2+D)+1 cycles after the start edge. For defaults this is cycle 45. `ready_o` is 1 again at cycle 46 (the cycle after the DONE cycle).
- `stage_o` updates on the ISSUE entry edge and holds through DRAIN.

## Configuration
- `FFT_SEQ_INV_EN` defined: adds port `inv_i` (in, 1), latched at start accept, and `tw_conj_o` (out, 1).
  - `tw_conj_o` equals the latched value, aligned with `bfly_valid_o`, so the butterfly uses conjugate twiddles (inverse FFT).
  - `tw_conj_o` resets to 0.
- Undefined: neither port exists; forward transform only.

## Structure
- Package `fft_pkg`:
  - `SAMPLE_W`=50 and `HALF_W`=25.
  - `sample_t` packed struct {re, im}.
  - FSM state enum `fft_seq_state_e`.
  - Shared with the butterfly.
- Sub-module `fft_seq_delay` (parameters WIDTH, DEPTH): a resettable shift register. It is instantiated for the valid/twiddle path (`RD_LAT`) and the write-address path (D).

## Test plan
- Reset then idle: `ready_o`=1 and every other output 0. `start_i` held 0 for 10 cycles → no `rd_en_o`.
- Stage 0 (defaults): cycles 1–3 give (a,b,tw) = (0,1,0), (2,3,0), (4,5,0). `stage_o`=0.
- Stage 2: k=0 → (0,4,0); k=1 → (1,5,2); k=4 → (8,12,0). Stage 3: k=3 → (3,11,3).
- Every `wr_en_o` appears exactly 3 cycles after its `rd_en_o` with identical addresses. No `rd_en_o` of stage s+1 occurs before the final `wr_en_o` of stage s.
- `done_o` is a single pulse at cycle 45. `start_i` pulsed at cycle 20 is ignored, giving exactly 32 `rd_en_o` cycles in total.
- `rst_i`=0 during stage 1 ISSUE: the next cycle has `rd_en_o`=`wr_en_o`=`bfly_valid_o`=0 and `ready_o`=1. No `wr_en_o` occurs in the 5 cycles after reset.
